// File: rtl/serv_bufreg_w_pkg.sv
// Shared types and helpers for the serial buffer register (address/JALR adder, streamer).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serv_bufreg_w_pkg;

  // Architectural register width; the block always walks one 32-bit word.
  localparam int ADR_W = 32;

  // Access size encoding as presented by the decoder.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Misalignment of a captured address for a given access size.
  // The reserved size encoding is always reported as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic m;
    m = 1'b1;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = lsb[0];
      SZ_WORD: m = |lsb;
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/serv_bufreg_w_if.sv
// Chunk-serial bus between decoder/state block and the buffer register.
// Latency: n/a (wiring only).
// Backpressure: none; the producer qualifies every chunk with i_en.
//
// Ports (seen from the buffer register, slave modport):
//   in : i_en, i_init, i_mdu_op, i_rs1_en, i_imm_en, i_clr_lsb, i_shift_op,
//        i_right_shift_op, i_sh_signed, i_size[1:0], i_rs1[W], i_imm[W], i_shamt_lsb[LB+1]
//   out: o_q[W], o_last, o_lsb[1:0], o_misalign, o_dbus_adr[32], o_ext_rs1[32]
interface serv_bufreg_w_if #(
  parameter int W  = 4,
  parameter int LB = $clog2(W)
);
  import serv_bufreg_w_pkg::*;

  logic             i_en;
  logic             i_init;
  logic             i_mdu_op;
  logic             i_rs1_en;
  logic             i_imm_en;
  logic             i_clr_lsb;
  logic             i_shift_op;
  logic             i_right_shift_op;
  logic             i_sh_signed;
  logic [1:0]       i_size;
  logic [W-1:0]     i_rs1;
  logic [W-1:0]     i_imm;
  logic [LB:0]      i_shamt_lsb;

  logic [W-1:0]     o_q;
  logic             o_last;
  logic [1:0]       o_lsb;
  logic             o_misalign;
  logic [ADR_W-1:0] o_dbus_adr;
  logic [ADR_W-1:0] o_ext_rs1;

  modport master (
    output i_en, i_init, i_mdu_op, i_rs1_en, i_imm_en, i_clr_lsb, i_shift_op,
           i_right_shift_op, i_sh_signed, i_size, i_rs1, i_imm, i_shamt_lsb,
    input  o_q, o_last, o_lsb, o_misalign, o_dbus_adr, o_ext_rs1
  );

  modport slave (
    input  i_en, i_init, i_mdu_op, i_rs1_en, i_imm_en, i_clr_lsb, i_shift_op,
           i_right_shift_op, i_sh_signed, i_size, i_rs1, i_imm, i_shamt_lsb,
    output o_q, o_last, o_lsb, o_misalign, o_dbus_adr, o_ext_rs1
  );

endinterface

// File: rtl/serv_bufreg_w_shift.sv
// Intra-chunk shifter: shifts each W-bit chunk and carries spilled bits into the next chunk.
// Latency: o_q combinational from i_d; spill register updates one cycle after each i_en.
// Backpressure: none; state advances only on i_en and is held otherwise.
//
// Ports: i_clk, i_rst_n, i_en (chunk valid), i_chunk0 (word start), i_shift_op,
//        i_right_shift_op, i_shamt_lsb[LB+1], i_d[W] (chunk in), o_q[W] (chunk out).
module serv_bufreg_w_shift #(
  parameter int W  = 4,
  parameter int LB = $clog2(W)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_chunk0,
  input  logic         i_shift_op,
  input  logic         i_right_shift_op,
  input  logic [LB:0]  i_shamt_lsb,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [LB:0]    w_s;
  logic [2*W-1:0] w_sh;
  // Upper half of the previous chunk's shifted value: the bits that spill
  // over the chunk boundary and belong in the next chunk.
  logic [W-1:0]   r_prev;

  // A right shift by n inside a chunk is a left shift by W-n whose result is
  // taken one chunk later, so both directions share one left shifter.
  always_comb begin
    w_s = '0;
    if (i_shift_op) begin
      if (!i_right_shift_op) begin
        w_s = i_shamt_lsb;
      end else if (i_shamt_lsb != '0) begin
        w_s = (LB+1)'(W) - i_shamt_lsb;
      end
    end
  end

  assign w_sh = {{W{1'b0}}, i_d} << w_s;
  assign o_q  = i_en ? (w_sh[W-1:0] | r_prev) : '0;

  // A load on i_en takes priority over the idle clear at word start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= '0;
    end else if (i_en) begin
      r_prev <= w_sh[2*W-1:W];
    end else if (i_chunk0) begin
      r_prev <= '0;
    end
  end

endmodule

// File: rtl/serv_bufreg_w.sv
// Buffer register: serial rs1+imm adder (dbus address / JALR target) and shifting word streamer.
// Latency: one W-bit chunk per i_en; o_dbus_adr final the cycle after o_last of an init pass.
// Backpressure: none; every i_en cycle consumes a chunk, idle cycles hold state and clear carry.
//
// Ports: i_clk, i_rst_n (async, active low), bus (serv_bufreg_w_if.slave):
//   control i_en/i_init/i_mdu_op/i_rs1_en/i_imm_en/i_clr_lsb/i_shift_op/i_right_shift_op/
//   i_sh_signed/i_size, data i_rs1/i_imm/i_shamt_lsb; results o_q/o_last/o_lsb/o_misalign/
//   o_dbus_adr/o_ext_rs1.
module serv_bufreg_w
  import serv_bufreg_w_pkg::*;
#(
  parameter int W   = 4,
  parameter int MDU = 0,
  parameter int LB  = $clog2(W)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  serv_bufreg_w_if.slave  bus
);

  localparam int CHUNKS = ADR_W / W;
  localparam int CW     = $clog2(CHUNKS);

  if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
    $error("serv_bufreg_w: W must be 1, 2, 4 or 8");
  end

  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic [ADR_W-1:0] r_data;
  logic [1:0]       r_lsb;

  logic             w_chunk0;
  logic             w_last_chunk;
  logic [W-1:0]     w_rs1;
  logic [W-1:0]     w_imm;
  logic [W:0]       w_sum;
  logic [W-1:0]     w_q;
  logic             w_c;
  logic [W-1:0]     w_fill;

  // Chunk position within the word.
  assign w_chunk0     = (r_cnt == '0);
  assign w_last_chunk = (r_cnt == CW'(CHUNKS-1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (bus.i_en) begin
      r_cnt <= w_last_chunk ? '0 : r_cnt + 1'b1;
    end
  end

  // Serial adder. JALR clears bit 0 of the target by masking imm bit 0 on chunk 0.
  always_comb begin
    w_rs1 = bus.i_rs1_en ? bus.i_rs1 : '0;
    w_imm = '0;
    if (bus.i_imm_en) begin
      w_imm = bus.i_imm;
      if (bus.i_clr_lsb && w_chunk0) begin
        w_imm[0] = 1'b0;
      end
    end
  end

  assign w_sum = {1'b0, w_rs1} + {1'b0, w_imm} + {{W{1'b0}}, r_c};
  assign w_q   = w_sum[W-1:0];
  assign w_c   = w_sum[W];

  // Carry only survives between consecutive chunks of the same word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c <= 1'b0;
    end else begin
      r_c <= w_c & bus.i_en & ~w_last_chunk;
    end
  end

  // Data register shifts right one chunk per i_en, new chunk enters at the top.
  assign w_fill = bus.i_sh_signed ? {W{r_data[ADR_W-1]}} : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (bus.i_en) begin
      r_data <= {bus.i_init ? w_q : w_fill, r_data[ADR_W-1:W]};
    end
  end

  // Address bits [1:0]: one chunk at W>=2, two consecutive bits at W=1.
  if (W >= 2) begin : g_lsb_wide
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_lsb <= '0;
      end else if (bus.i_en && bus.i_init && w_chunk0) begin
        r_lsb <= w_q[1:0];
      end
    end
  end else begin : g_lsb_serial
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_lsb <= '0;
      end else if (bus.i_en && bus.i_init && (r_cnt < CW'(2))) begin
        r_lsb <= {w_q, r_lsb[1]};
      end
    end
  end

  serv_bufreg_w_shift #(
    .W  (W),
    .LB (LB)
  ) u_shift (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_en             (bus.i_en),
    .i_chunk0         (w_chunk0),
    .i_shift_op       (bus.i_shift_op),
    .i_right_shift_op (bus.i_right_shift_op),
    .i_shamt_lsb      (bus.i_shamt_lsb),
    .i_d              (r_data[W-1:0]),
    .o_q              (bus.o_q)
  );

  assign bus.o_last     = bus.i_en & w_last_chunk;
  // The MDU reuses the lsb path for its own purposes; hide it from the LSU then.
  assign bus.o_lsb      = ((MDU != 0) && bus.i_mdu_op) ? 2'b00 : r_lsb;
  assign bus.o_misalign = misaligned(bus.i_size, r_lsb);
  assign bus.o_dbus_adr = {r_data[ADR_W-1:2], 2'b00};
  assign bus.o_ext_rs1  = r_data;

endmodule

// File: tb/tb_serv_bufreg_w.sv
// Self-checking bench for serv_bufreg_w at W=4 (MDU=0) and W=1/W=8 (MDU=1).
// Latency: n/a.
// Backpressure: n/a.
module tb_serv_bufreg_w;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serv_bufreg_w_if #(.W(4)) bus4 ();
  serv_bufreg_w_if #(.W(1)) bus1 ();
  serv_bufreg_w_if #(.W(8)) bus8 ();

  serv_bufreg_w #(.W(4), .MDU(0)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4));
  serv_bufreg_w #(.W(1), .MDU(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
  serv_bufreg_w #(.W(8), .MDU(1)) dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8));

  // Shared stimulus; each DUT gets its own enable and its slice of the word.
  logic        en1, en4, en8;
  logic        init, mdu_op, rs1_en, imm_en, clr_lsb, shift_op, right, sh_signed;
  logic [1:0]  size;
  logic [31:0] rs1_w, imm_w;
  logic [3:0]  shamt;
  int          chunk;

  assign bus4.i_en = en4;            assign bus1.i_en = en1;            assign bus8.i_en = en8;
  assign bus4.i_init = init;         assign bus1.i_init = init;         assign bus8.i_init = init;
  assign bus4.i_mdu_op = mdu_op;     assign bus1.i_mdu_op = mdu_op;     assign bus8.i_mdu_op = mdu_op;
  assign bus4.i_rs1_en = rs1_en;     assign bus1.i_rs1_en = rs1_en;     assign bus8.i_rs1_en = rs1_en;
  assign bus4.i_imm_en = imm_en;     assign bus1.i_imm_en = imm_en;     assign bus8.i_imm_en = imm_en;
  assign bus4.i_clr_lsb = clr_lsb;   assign bus1.i_clr_lsb = clr_lsb;   assign bus8.i_clr_lsb = clr_lsb;
  assign bus4.i_shift_op = shift_op; assign bus1.i_shift_op = shift_op; assign bus8.i_shift_op = shift_op;
  assign bus4.i_right_shift_op = right;
  assign bus1.i_right_shift_op = right;
  assign bus8.i_right_shift_op = right;
  assign bus4.i_sh_signed = sh_signed;
  assign bus1.i_sh_signed = sh_signed;
  assign bus8.i_sh_signed = sh_signed;
  assign bus4.i_size = size;         assign bus1.i_size = size;         assign bus8.i_size = size;
  assign bus4.i_rs1 = rs1_w[(chunk % 8) * 4 +: 4];
  assign bus4.i_imm = imm_w[(chunk % 8) * 4 +: 4];
  assign bus1.i_rs1 = rs1_w[chunk % 32];
  assign bus1.i_imm = imm_w[chunk % 32];
  assign bus8.i_rs1 = rs1_w[(chunk % 4) * 8 +: 8];
  assign bus8.i_imm = imm_w[(chunk % 4) * 8 +: 8];
  assign bus4.i_shamt_lsb = shamt[2:0];
  assign bus1.i_shamt_lsb = 1'b0;
  assign bus8.i_shamt_lsb = shamt;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb_val[$];
  string       sb_tag[$];
  logic [31:0] stream_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_tag.push_back(tag);
    sb_val.push_back(v);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    if (sb_val.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_underflow: got 0x%08h with nothing expected", obs);
    end else begin
      check(sb_tag.pop_front(), obs, sb_val.pop_front());
    end
  endtask

  function automatic logic [31:0] get_q(input int w);
    case (w)
      1:       return 32'(bus1.o_q);
      8:       return 32'(bus8.o_q);
      default: return 32'(bus4.o_q);
    endcase
  endfunction

  function automatic logic [31:0] get_last(input int w);
    case (w)
      1:       return 32'(bus1.o_last);
      8:       return 32'(bus8.o_last);
      default: return 32'(bus4.o_last);
    endcase
  endfunction

  function automatic logic [31:0] get_ext(input int w);
    case (w)
      1:       return bus1.o_ext_rs1;
      8:       return bus8.o_ext_rs1;
      default: return bus4.o_ext_rs1;
    endcase
  endfunction

  function automatic logic [31:0] get_adr(input int w);
    case (w)
      1:       return bus1.o_dbus_adr;
      8:       return bus8.o_dbus_adr;
      default: return bus4.o_dbus_adr;
    endcase
  endfunction

  function automatic logic [31:0] get_lsb(input int w);
    case (w)
      1:       return 32'(bus1.o_lsb);
      8:       return 32'(bus8.o_lsb);
      default: return 32'(bus4.o_lsb);
    endcase
  endfunction

  task automatic set_en(input int w, input logic e);
    en1 = (w == 1) && e;
    en4 = (w == 4) && e;
    en8 = (w == 8) && e;
  endtask

  // One full word pass; optional idle cycle inserted before chunk gap_at.
  // Inputs change on the falling edge, outputs are sampled 1 time unit later.
  task automatic run_pass(input int w, input logic [31:0] rs1, input logic [31:0] imm,
                          input bit chk_last, input bit chk_q, input int gap_at);
    int n;
    n = 32 / w;
    rs1_w = rs1;
    imm_w = imm;
    stream_word = '0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        @(negedge clk); set_en(w, 1'b0); #1;
        if (chk_q) sb_check(get_q(w));
      end
      @(negedge clk); chunk = i; set_en(w, 1'b1); #1;
      if (chk_last) check($sformatf("o_last[%0d]", i), get_last(w), 32'(i == n - 1));
      if (chk_q) sb_check(get_q(w));
      stream_word = stream_word | (get_q(w) << (i * w));
    end
    @(negedge clk); set_en(w, 1'b0); #1;
  endtask

  task automatic load(input int w, input logic [31:0] v);
    init = 1'b1;
    shift_op = 1'b0;
    run_pass(w, v, 32'h0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    logic [31:0] a, b, s, v;
    int ws[2];
    ws = '{1, 8};
    en1 = 0; en4 = 0; en8 = 0;
    init = 0; mdu_op = 0; rs1_en = 1; imm_en = 1; clr_lsb = 0;
    shift_op = 0; right = 0; sh_signed = 0; size = 2'b00;
    rs1_w = '0; imm_w = '0; chunk = 0; shamt = '0; stream_word = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    check("rst_q", get_q(4), 32'h0);
    check("rst_last", get_last(4), 32'h0);
    check("rst_lsb", get_lsb(4), 32'h0);
    check("rst_mis", 32'(bus4.o_misalign), 32'h0);
    check("rst_adr", get_adr(4), 32'h0);
    check("rst_ext", get_ext(4), 32'h0);
    check("rst_ext_w1", get_ext(1), 32'h0);
    check("rst_ext_w8", get_ext(8), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Address add with carry across chunks, o_last on the final chunk only.
    init = 1'b1; size = 2'b10;
    sb_push("sum_ff_3", 32'h0000_0102);
    run_pass(4, 32'h0000_00FF, 32'h0000_0003, 1'b1, 1'b0, -1);
    sb_check(get_ext(4));
    check("adr_ff_3", get_adr(4), 32'h0000_0100);
    check("lsb_ff_3", get_lsb(4), 32'h2);
    check("mis_word", 32'(bus4.o_misalign), 32'h1);
    size = 2'b01; #1 check("mis_half", 32'(bus4.o_misalign), 32'h0);
    size = 2'b00; #1 check("mis_byte", 32'(bus4.o_misalign), 32'h0);
    size = 2'b11; #1 check("mis_rsvd", 32'(bus4.o_misalign), 32'h1);
    size = 2'b10;

    // JALR target with and without bit-0 clear.
    clr_lsb = 1'b1;
    sb_push("jalr_clr", 32'h0000_0104);
    run_pass(4, 32'h0000_0100, 32'h0000_0005, 1'b0, 1'b0, -1);
    sb_check(get_ext(4));
    clr_lsb = 1'b0;
    sb_push("jalr_noclr", 32'h0000_0105);
    run_pass(4, 32'h0000_0100, 32'h0000_0005, 1'b0, 1'b0, -1);
    sb_check(get_ext(4));

    // Signed and zero refill while streaming.
    load(4, 32'h8000_0000);
    init = 1'b0; sh_signed = 1'b1;
    sb_push("fill_signed", 32'hFFFF_FFFF);
    run_pass(4, 32'h0, 32'h0, 1'b0, 1'b0, -1);
    sb_check(get_ext(4));
    load(4, 32'h8000_0000);
    init = 1'b0; sh_signed = 1'b0;
    sb_push("fill_zero", 32'h0000_0000);
    run_pass(4, 32'h0, 32'h0, 1'b0, 1'b0, -1);
    sb_check(get_ext(4));

    // Left shift by 1 with an idle cycle mid-word: chunks of (word << s).
    load(4, 32'h0000_0003);
    init = 1'b0; shift_op = 1'b1; right = 1'b0; shamt = 4'd1;
    v = 32'h0000_0003 << 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) sb_push("q_idle", 32'h0);
      sb_push($sformatf("qL[%0d]", i), (v >> (4 * i)) & 32'hF);
    end
    run_pass(4, 32'h0, 32'h0, 1'b0, 1'b1, 3);
    check("stream_left", stream_word, 32'h0000_0006);

    // Right shift by 1 uses in-chunk shift W-1, i.e. chunks of (word << 3).
    load(4, 32'h1234_5678);
    init = 1'b0; shift_op = 1'b1; right = 1'b1; shamt = 4'd1;
    v = 32'h1234_5678 << 3;
    for (int i = 0; i < 8; i++) sb_push($sformatf("qR[%0d]", i), (v >> (4 * i)) & 32'hF);
    run_pass(4, 32'h0, 32'h0, 1'b0, 1'b1, -1);
    check("stream_right", stream_word, v);
    shift_op = 1'b0; right = 1'b0; shamt = '0;

    // W=1 and W=8 random sums, lsb capture and MDU masking.
    init = 1'b1; size = 2'b10;
    foreach (ws[j]) begin
      for (int k = 0; k < 3; k++) begin
        a = $urandom; b = $urandom; s = a + b;
        sb_push($sformatf("sum_w%0d_%0d", ws[j], k), s);
        run_pass(ws[j], a, b, k == 0, 1'b0, -1);
        sb_check(get_ext(ws[j]));
        check($sformatf("adr_w%0d_%0d", ws[j], k), get_adr(ws[j]), {s[31:2], 2'b00});
        check($sformatf("lsb_w%0d_%0d", ws[j], k), get_lsb(ws[j]), 32'(s[1:0]));
        if (ws[j] == 8) check($sformatf("mis_w8_%0d", k), 32'(bus8.o_misalign), 32'(|s[1:0]));
        mdu_op = 1'b1;
        #1 check($sformatf("lsb_mdu_w%0d_%0d", ws[j], k), get_lsb(ws[j]), 32'h0);
        mdu_op = 1'b0;
      end
    end

    // Reset in chunk 3 of a pass holding a live carry, then a clean pass.
    init = 1'b1; size = 2'b00; rs1_w = 32'h0000_0FFF; imm_w = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chunk = i; en4 = 1'b1;
    end
    @(negedge clk); chunk = 3; en4 = 1'b1; #1;
    rst_n = 1'b0; #1;
    check("midrst_q", get_q(4), 32'h0);
    check("midrst_last", get_last(4), 32'h0);
    check("midrst_lsb", get_lsb(4), 32'h0);
    check("midrst_mis", 32'(bus4.o_misalign), 32'h0);
    check("midrst_adr", get_adr(4), 32'h0);
    check("midrst_ext", get_ext(4), 32'h0);
    @(negedge clk); en4 = 1'b0; rst_n = 1'b1;
    sb_push("post_rst_sum", 32'h0000_0030);
    run_pass(4, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, -1);
    sb_check(get_ext(4));

    check("sb_drain", 32'(sb_val.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
